aes_128_key_expand: RTL

On-the-fly AES-128 round-key generator that drives key_round of the AES-128 core.
- A cipher key is loaded once.
- Each key_ready pulse from the control block advances key_round to the next round key, rounds 0..10.
- After round 10 the block rewinds to round 0 for the next data block.
- S-box lookups (4 bytes, SubWord of RotWord) use the same registered-ROM style as the datapath.

---
 rtl/aes_128_key_expand_if.sv | 23 ++
 rtl/aes_128_key_expand.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/aes_128_key_expand_if.sv
// Interface bundle between the AES-128 control/core side and the on-the-fly
// round-key generator.
interface aes_128_key_expand_if;
  logic         kill;
  logic [127:0] key_in;
  logic         key_load;
  logic         key_ready;
  logic [127:0] key_round;
  logic         key_valid;
  logic [3:0]   round_num;
  logic         last_round;
  logic         key_collision_irq_pulse;

  modport master (
    output kill, key_in, key_load, key_ready,
    input  key_round, key_valid, round_num, last_round, key_collision_irq_pulse
  );

  modport slave (
    input  kill, key_in, key_load, key_ready,
    output key_round, key_valid, round_num, last_round, key_collision_irq_pulse
  );
endinterface

// File: rtl/aes_128_key_expand.sv
// On-the-fly AES-128 round-key generator (rounds 0..10, rewinds after round 10).
// Optional macro AES_KEY_CACHE_EN adds an 11-entry round-key cache for later passes.
module aes_128_key_expand #(
  parameter int SBOX_REG = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  aes_128_key_expand_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READY, SUB, MIX} state_t;

  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte of the ROM, so the bit offset is ~a * 8.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_ROM[{~a, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_for(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state, state_next;
  logic [127:0] key_round, key_next;
  logic [127:0] key0;
  logic [3:0]   round_num, round_next;
  logic         key_valid, valid_next;
  logic         irq_pulse;
  logic [31:0]  sub_q, sub_next;

  logic [31:0]  sub_comb, sub_sel, t_word;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] mix_key;

`ifdef AES_KEY_CACHE_EN
  logic [127:0] cache [0:10];
  logic         cache_full;
`endif

  // key_round is frozen during SUB/MIX, so w3 can feed the S-box directly.
  always_comb begin
    sub_comb = sub_word({key_round[23:0], key_round[31:24]});
    sub_sel  = (SBOX_REG != 0) ? sub_q : sub_comb;
    t_word   = sub_sel ^ {rcon_for(round_num + 4'd1), 24'h000000};
    w0_n     = key_round[127:96] ^ t_word;
    w1_n     = key_round[95:64] ^ w0_n;
    w2_n     = key_round[63:32] ^ w1_n;
    w3_n     = key_round[31:0] ^ w2_n;
    mix_key  = {w0_n, w1_n, w2_n, w3_n};
  end

  // key_load beats kill, which beats any in-flight expansion.
  always_comb begin
    state_next = state;
    key_next   = key_round;
    round_next = round_num;
    valid_next = key_valid;
    sub_next   = sub_q;
    if (bus.key_load) begin
      state_next = READY;
      key_next   = bus.key_in;
      round_next = 4'd0;
      valid_next = 1'b1;
    end else if (bus.kill) begin
      if (state != IDLE) begin
        state_next = READY;
        key_next   = key0;
        round_next = 4'd0;
        valid_next = 1'b1;
      end
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        READY: begin
          if (bus.key_ready) begin
            if (round_num == 4'd10) begin
              key_next   = key0;
              round_next = 4'd0;
`ifdef AES_KEY_CACHE_EN
            end else if (cache_full) begin
              key_next   = cache[round_num + 4'd1];
              round_next = round_num + 4'd1;
`endif
            end else begin
              valid_next = 1'b0;
              state_next = (SBOX_REG != 0) ? SUB : MIX;
            end
          end
        end
        SUB: begin
          sub_next   = sub_comb;
          state_next = MIX;
        end
        MIX: begin
          key_next   = mix_key;
          round_next = round_num + 4'd1;
          valid_next = 1'b1;
          state_next = READY;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_round <= '0;
      key0      <= '0;
      round_num <= 4'd0;
      key_valid <= 1'b0;
      sub_q     <= '0;
      irq_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      key_round <= key_next;
      round_num <= round_next;
      key_valid <= valid_next;
      sub_q     <= sub_next;
      irq_pulse <= bus.key_ready && ((state == SUB) || (state == MIX));
      if (bus.key_load) key0 <= bus.key_in;
    end
  end

`ifdef AES_KEY_CACHE_EN
  // Each freshly mixed key lands in its slot; a completed pass marks the cache full.
  always_ff @(posedge clk) begin
    if (bus.key_load)
      cache[0] <= bus.key_in;
    else if (!bus.kill && state == MIX)
      cache[round_num + 4'd1] <= mix_key;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cache_full <= 1'b0;
    else if (bus.key_load)
      cache_full <= 1'b0;
    else if (!bus.kill && state == READY && bus.key_ready && round_num == 4'd10)
      cache_full <= 1'b1;
  end
`endif

  assign bus.key_round               = key_round;
  assign bus.key_valid               = key_valid;
  assign bus.round_num               = round_num;
  assign bus.last_round              = (round_num == 4'd10);
  assign bus.key_collision_irq_pulse = irq_pulse;

endmodule
